// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised RV32 data memory behind a valid/ready request port.
// Handles LB/LH/LW/LBU/LHU loads and SB/SH/SW stores (read-modify-write of a
// whole word), a programmable number of wait states, and flags misaligned,
// out-of-range and illegal-funct3 requests with an error response.
module dmem_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] INIT_WORD   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    funct3_q;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          latch_en;
    logic          acc_en;

    // Contents are preset once at configuration time; reset never touches them.
    logic [31:0]   mem_q [DEPTH_WORDS] = '{default: INIT_WORD};

    // Request rejection rules, evaluated on the live request at acceptance.
    function automatic logic access_err(input logic we, input logic [31:0] addr,
                                        input logic [2:0] f3);
        logic bad_f3;
        logic misal;
        logic oor;
        if (we) begin
            bad_f3 = f3[2] || (f3[1:0] == 2'b11);
        end else begin
            bad_f3 = (f3[1:0] == 2'b11) || (f3 == 3'b110);
        end
        misal = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        oor   = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        return bad_f3 || misal || oor;
    endfunction

    logic          req_err;
    logic          use_live;
    logic          acc_we;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [2:0]    acc_funct3;
    logic [AW-1:0] acc_idx;
    logic [31:0]   rd_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_rep;
    logic [31:0]   merged;

    assign req_err = access_err(req_we, req_addr, req_funct3);

    // With no wait states the access happens in IDLE on the live inputs;
    // otherwise it happens at the end of WAIT on the latched request.
    assign use_live   = (state_q == S_IDLE);
    assign acc_we     = use_live ? req_we               : we_q;
    assign acc_addr   = use_live ? req_addr[AW+1:0]     : addr_q;
    assign acc_wdata  = use_live ? req_wdata            : wdata_q;
    assign acc_funct3 = use_live ? req_funct3           : funct3_q;
    assign acc_idx    = acc_addr[AW+1:2];
    assign rd_word    = mem_q[acc_idx];
    assign shifted    = rd_word >> {acc_addr[1:0], 3'b000};

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        load_data = rd_word;
        case (acc_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = rd_word;
        endcase
    end

    // Byte enables and lane-replicated store data for the store merge.
    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = acc_wdata;
        case (acc_funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << acc_addr[1:0];
                wdata_rep = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{acc_wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = acc_wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    // Next-state logic, access strobe and response data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        latch_en     = 1'b0;
        acc_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (WAIT_CYCLES == 0) begin
                        acc_en  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (acc_en) begin
            resp_err_d   = 1'b0;
            resp_rdata_d = acc_we ? 32'd0 : load_data;
        end
    end

    // Control state, latched request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            funct3_q     <= 3'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (latch_en) begin
                we_q     <= req_we;
                addr_q   <= req_addr[AW+1:0];
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
            end
        end
    end

    // Store commit: whole-word write of the merged lanes; blocked while in reset.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we && rst_n) begin
            mem_q[acc_idx] <= merged;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: two instances (1 and 3 wait states) driven with
// directed and random requests; a monitor checks every response against a
// queue of expectations filled when each request is accepted.
module tb_dmem_lsu;

    localparam int          DEPTH = 1024;
    localparam int          W0    = 1;
    localparam int          W1    = 3;
    localparam logic [31:0] INIT  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cnt [2];

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    logic [31:0] model_mem [int];

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .INIT_WORD(INIT)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_funct3(req_funct3[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0])
    );

    dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .INIT_WORD(INIT)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_funct3(req_funct3[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic int pending(input int d);
        int n = 0;
        foreach (sb_q[i]) if (sb_q[i].dut == d) n++;
        return n;
    endfunction

    // Reference model: byte-addressed little-endian memory per instance.
    function automatic void ref_access(input int d, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] f3,
                                       output logic [31:0] rd, output logic e);
        logic        legal;
        int          size;
        int          lane;
        int          key;
        logic [31:0] w;
        logic [31:0] mask;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = 1 << f3[1:0];
        rd   = 32'd0;
        e    = !legal || ((addr % 32'(size)) != 32'd0) || ((addr >> 2) >= 32'(DEPTH));
        if (e) return;
        key  = d * 4096 + int'(addr >> 2);
        w    = model_mem.exists(key) ? model_mem[key] : INIT;
        lane = int'(addr % 32'd4);
        if (we) begin
            for (int i = 0; i < size; i++) w[8*(lane+i) +: 8] = wdata[8*i +: 8];
            model_mem[key] = w;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            rd   = (w >> (8 * lane)) & mask;
            if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | ~mask;
        end
    endfunction

    // Issue one request (caller is just after a rising edge), push its
    // expectation, then follow req_ready through the busy window.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic use_lit, input logic [31:0] lit_rd, input logic lit_err);
        logic [31:0] m_rd;
        logic        m_err;
        logic [31:0] e_rd;
        logic        e_err;
        int          w;
        int          k;
        int          lat;
        int          n;
        exp_t        ent;
        ref_access(d, we, addr, wdata, f3, m_rd, m_err);
        e_rd  = use_lit ? lit_rd  : m_rd;
        e_err = use_lit ? lit_err : m_err;
        w     = (d == 0) ? W0 : W1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_funct3[d] = f3;
        req_valid[d]  = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut=%0d got=0 exp=1", d);
            req_valid[d] = 1'b0;
            return;
        end
        k = cyc + 1;
        ent.dut   = d;
        ent.cyc   = k + (e_err ? 0 : w);
        ent.rdata = e_rd;
        ent.err   = e_err;
        sb_q.push_back(ent);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = e_err ? 1 : w + 1;
        for (int j = 0; j < lat; j++) begin
            check("ready_busy", 32'(req_ready[d]), 32'd0);
            @(posedge clk); #1;
        end
        check("ready_back", 32'(req_ready[d]), 32'd1);
        check("resp_missing", 32'(pending(d)), 32'd0);
    endtask

    // Scoreboard monitor: every response pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (resp_valid[d]) begin
                if (sb_q.size() == 0 || sb_q[0].dut != d) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp dut=%0d cyc=%0d got rdata=%h err=%0d exp=none",
                             d, cyc, resp_rdata[d], resp_err[d]);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    check("resp_rdata", resp_rdata[d], e.rdata);
                    check("resp_err", 32'(resp_err[d]), 32'(e.err));
                end
            end
        end
    end

    // Count acceptances: inputs are stable at the falling edge before the accepting edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] && req_valid[d] && req_ready[d]) acc_cnt[d] = acc_cnt[d] + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] m_rd;
        logic        m_err;
        int          k;
        int          a0;
        int          r;
        logic [2:0]  f3;
        logic        we;
        exp_t        ent;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_funct3[d] = 3'd0;
            acc_cnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd1);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_rdata", resp_rdata[d], 32'd0);
            check("rst_err", 32'(resp_err[d]), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Directed sequence on the 1-wait-state instance.
        issue(0, 1'b0, 32'h14, 32'h0,         3'b010, 1'b1, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b1, 32'h10, 32'h1234_5678, 3'b010, 1'b1, 32'h0,         1'b0);
        issue(0, 1'b0, 32'h11, 32'h0,         3'b000, 1'b1, 32'h0000_0056, 1'b0);
        issue(0, 1'b0, 32'h13, 32'h0,         3'b100, 1'b1, 32'h0000_0012, 1'b0);
        issue(0, 1'b0, 32'h12, 32'h0,         3'b001, 1'b1, 32'h0000_1234, 1'b0);
        issue(0, 1'b1, 32'h10, 32'h0000_80F0, 3'b010, 1'b1, 32'h0,         1'b0);
        issue(0, 1'b0, 32'h10, 32'h0,         3'b000, 1'b1, 32'hFFFF_FFF0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0,         3'b001, 1'b1, 32'hFFFF_80F0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0,         3'b101, 1'b1, 32'h0000_80F0, 1'b0);
        issue(0, 1'b1, 32'h21, 32'h0000_00AB, 3'b000, 1'b1, 32'h0,         1'b0);
        issue(0, 1'b0, 32'h20, 32'h0,         3'b010, 1'b1, 32'hDEAD_ABEF, 1'b0);
        issue(0, 1'b1, 32'h22, 32'h0000_1234, 3'b001, 1'b1, 32'h0,         1'b0);
        issue(0, 1'b0, 32'h20, 32'h0,         3'b010, 1'b1, 32'h1234_ABEF, 1'b0);
        issue(0, 1'b0, 32'h22, 32'h0,         3'b010, 1'b1, 32'h0,         1'b1);
        issue(0, 1'b1, 32'h23, 32'h0000_5555, 3'b001, 1'b1, 32'h0,         1'b1);
        issue(0, 1'b0, 32'h20, 32'h0,         3'b010, 1'b1, 32'h1234_ABEF, 1'b0);
        issue(0, 1'b0, 32'h21, 32'h0,         3'b001, 1'b1, 32'h0,         1'b1);
        issue(0, 1'b0, 32'h1000, 32'h0,       3'b010, 1'b1, 32'h0,         1'b1);
        issue(0, 1'b0, 32'h0,  32'h0,         3'b011, 1'b1, 32'h0,         1'b1);
        issue(0, 1'b1, 32'h0,  32'h5A5A_5A5A, 3'b100, 1'b1, 32'h0,         1'b1);
        issue(0, 1'b0, 32'h0,  32'h0,         3'b010, 1'b1, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b0, 32'hFFC, 32'h0,        3'b010, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Held request on the 3-wait-state instance: two acceptances 5 cycles apart.
        a = 32'h40;
        ref_access(1, 1'b0, a, 32'h0, 3'b010, m_rd, m_err);
        req_we[1] = 1'b0; req_addr[1] = a; req_wdata[1] = 32'h0; req_funct3[1] = 3'b010;
        req_valid[1] = 1'b1;
        k  = cyc + 1;
        a0 = acc_cnt[1];
        ent.dut = 1; ent.rdata = m_rd; ent.err = m_err;
        ent.cyc = k + W1;
        sb_q.push_back(ent);
        ent.cyc = k + 5 + W1;
        sb_q.push_back(ent);
        repeat (10) @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("held_accepts", 32'(acc_cnt[1] - a0), 32'd2);
        check("held_pending", 32'(pending(1)), 32'd0);

        // Store aborted by reset in its second wait cycle.
        req_we[1] = 1'b1; req_addr[1] = 32'h30; req_wdata[1] = 32'hCAFE_F00D; req_funct3[1] = 3'b010;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("abort_busy", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #2;
        rst_n[1] = 1'b0;
        #1;
        check("abort_rst_ready", 32'(req_ready[1]), 32'd1);
        check("abort_rst_valid", 32'(resp_valid[1]), 32'd0);
        check("abort_rst_rdata", resp_rdata[1], 32'd0);
        @(posedge clk); #2;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h30, 32'h0, 3'b010, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Random traffic on both instances, checked against the model.
        for (int i = 0; i < 160; i++) begin
            int d;
            d = (i < 100) ? 0 : 1;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'hFF8 + $urandom_range(0, 15);
            else             a = $urandom_range(0, 63);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                r  = int'($urandom_range(0, we ? 2 : 4));
                f3 = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            issue(d, we, a, $urandom, f3, 1'b0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
